// File: rtl/udp_tx_fifo_ctrl.sv
// Drains a byte FIFO into fixed-length UDP payload packets with request/ack handshake and IFG.
// Optional macro FLUSH_TIMEOUT_EN: flush a partial packet after FLUSH_CYC idle cycles.
module udp_tx_fifo_ctrl #(
  parameter int unsigned PKT_LEN   = 1024,
  parameter int unsigned FLUSH_CYC = 65535,
  parameter int unsigned IFG_CYC   = 12
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [11:0] fifo_rdusedw,
  input  logic        fifo_empty,
  output logic        fifo_re,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_valid,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [15:0] tx_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [11:0] PktLenRd = 12'(PKT_LEN);
  localparam logic [15:0] PktLenTx = 16'(PKT_LEN);
  localparam logic [15:0] GapLast  = (IFG_CYC > 0) ? 16'(IFG_CYC - 1) : 16'd0;

  typedef enum logic [1:0] {StIdle, StReq, StStream, StGap} state_e;

  state_e          r_state, w_state_d;
  logic [15:0]     r_tx_len, w_tx_len_d;
  logic [15:0]     r_rd_rem;
  logic [15:0]     r_tx_rem;
  logic            r_inflight;
  logic [1:0][7:0] r_skid, w_skid_d;
  logic [1:0]      r_skid_cnt, w_skid_cnt_d;
  logic [15:0]     r_pkt_cnt;
  logic [15:0]     r_gap_cnt;
  logic            w_pop, w_push, w_done, w_full_pkt, w_flush_hit;
  logic [2:0]      w_occ;

  assign w_pop      = (r_skid_cnt != 2'd0) && tx_ready;
  assign w_push     = fifo_valid && r_inflight;
  assign w_done     = w_pop && (r_tx_rem == 16'd1);
  assign w_full_pkt = (fifo_rdusedw >= PktLenRd);
  // Occupancy after this cycle's pop, so a steady stream can keep one read in flight every cycle.
  assign w_occ      = 3'(r_skid_cnt) - 3'(w_pop) + 3'(r_inflight);

`ifdef FLUSH_TIMEOUT_EN
  logic [31:0] r_flush_cnt;
  logic        w_partial;

  assign w_partial   = (fifo_rdusedw != 12'd0) && (fifo_rdusedw < PktLenRd);
  assign w_flush_hit = w_partial && (r_flush_cnt == FLUSH_CYC);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_flush_cnt <= '0;
    end else if ((r_state == StIdle) && w_partial) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end else begin
      r_flush_cnt <= '0;
    end
  end
`else
  logic w_unused_flush;
  assign w_flush_hit    = 1'b0;
  assign w_unused_flush = ^FLUSH_CYC;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_tx_len_d = r_tx_len;
    unique case (r_state)
      StIdle: begin
        if (w_full_pkt) begin
          w_state_d  = StReq;
          w_tx_len_d = PktLenTx;
        end else if (w_flush_hit) begin
          w_state_d  = StReq;
          w_tx_len_d = {4'd0, fifo_rdusedw};
        end
      end
      StReq:    if (tx_ack) w_state_d = StStream;
      StStream: if (w_done) w_state_d = StGap;
      StGap:    if (r_gap_cnt == GapLast) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_req   = (r_state == StReq);
    busy     = (r_state != StIdle);
    fifo_re  = !srst && (r_state == StStream) && (r_rd_rem != 16'd0) && !fifo_empty &&
               (w_occ < 3'd2);
    tx_valid = (r_skid_cnt != 2'd0);
    tx_data  = r_skid[0];
    tx_last  = tx_valid && (r_tx_rem == 16'd1);
    tx_len   = r_tx_len;
    pkt_cnt  = r_pkt_cnt;
  end

  // Two-entry skid: slot 0 is always the head presented on tx_data.
  always_comb begin
    w_skid_d     = r_skid;
    w_skid_cnt_d = r_skid_cnt;
    if (w_pop) begin
      w_skid_d[0]  = r_skid[1];
      w_skid_cnt_d = r_skid_cnt - 2'd1;
    end
    if (w_push) begin
      if (w_skid_cnt_d == 2'd0) begin
        w_skid_d[0] = fifo_dout;
      end else begin
        w_skid_d[1] = fifo_dout;
      end
      w_skid_cnt_d = w_skid_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_tx_len   <= '0;
      r_rd_rem   <= '0;
      r_tx_rem   <= '0;
      r_inflight <= 1'b0;
      r_skid     <= '0;
      r_skid_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_len   <= w_tx_len_d;
      r_inflight <= fifo_re;
      r_skid     <= w_skid_d;
      r_skid_cnt <= w_skid_cnt_d;
      if ((r_state == StReq) && tx_ack) begin
        r_rd_rem <= r_tx_len;
        r_tx_rem <= r_tx_len;
      end else begin
        if (fifo_re) r_rd_rem <= r_rd_rem - 16'd1;
        if (w_pop)   r_tx_rem <= r_tx_rem - 16'd1;
      end
      if (w_done) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      r_gap_cnt <= (r_state == StGap) ? r_gap_cnt + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_udp_tx_fifo_ctrl.sv
// Directed/randomized bench for udp_tx_fifo_ctrl with a queue-based FIFO and packet scoreboard.
// Covers the FLUSH_TIMEOUT_EN build when that macro is defined.
module tb_udp_tx_fifo_ctrl;

  localparam int PktLen = 16;
  localparam int Ifg    = 12;
  localparam int Flush  = 100;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [11:0] fifo_rdusedw = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_re;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_valid = 1'b0;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic [15:0] tx_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic [15:0] pkt_cnt;

  udp_tx_fifo_ctrl #(.PKT_LEN(PktLen), .FLUSH_CYC(Flush), .IFG_CYC(Ifg)) dut (
    .clk(clk), .srst(srst), .fifo_rdusedw(fifo_rdusedw), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .tx_req(tx_req),
    .tx_ack(tx_ack), .tx_len(tx_len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fq[$];         // bytes sitting in the FIFO
  logic [7:0] exp_bytes[$];  // every byte still owed to the transmitter, in order
  int cur_len = PktLen;
  int pos = 0;
  int exp_pkts = 0;
  int n_xfer = 0;
  int first_xfer = -1;
  int last_xfer = -1;
  int req_cyc = 0;
  bit stall_q = 1'b0;
  logic [7:0] hold_data = '0;
  logic hold_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_flags();
    fifo_rdusedw = 12'(fq.size());
    fifo_empty   = (fq.size() == 0);
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 8'(i));
      exp_bytes.push_back(base + 8'(i));
    end
    fifo_flags();
  endtask

  // Sample at negedge, then advance one clock and model the FIFO's registered read.
  task automatic tick();
    logic re;
    logic xfer;
    logic [7:0] e;
    @(negedge clk);
    re   = fifo_re;
    xfer = tx_valid && tx_ready && !srst;
    if (stall_q && !srst) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(hold_data));
      chk("hold_last", 32'(tx_last), 32'(hold_last));
    end
    stall_q   = tx_valid && !tx_ready && !srst;
    hold_data = tx_data;
    hold_last = tx_last;
    if (xfer) begin
      n_xfer++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (exp_bytes.size() == 0) begin
        chk("extra_byte", 32'd1, 32'd0);
      end else begin
        e = exp_bytes.pop_front();
        chk("data", 32'(tx_data), 32'(e));
        chk("last", 32'(tx_last), 32'(pos == cur_len - 1));
        pos++;
        if (pos == cur_len) begin
          pos = 0;
          exp_pkts++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    fifo_valid = 1'b0;
    if (re && !srst) begin
      if (fq.size() == 0) begin
        chk("read_when_empty", 32'd1, 32'd0);
      end else begin
        fifo_dout  = fq.pop_front();
        fifo_valid = 1'b1;
      end
    end
    fifo_flags();
  endtask

  task automatic run_packet(input int ack_delay, input int len, input bit rnd);
    int n;
    int start;
    int stream_cyc;
    n = 0;
    while (!tx_req && n < 400) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(tx_req), 32'd1);
    if (tx_req) begin
      req_cyc = cyc;
      chk("tx_len", 32'(tx_len), 32'(len));
      cur_len = len;
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        chk("req_hold", 32'(tx_req), 32'd1);
        chk("len_hold", 32'(tx_len), 32'(len));
      end
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("req_drop", 32'(tx_req), 32'd0);
      stream_cyc = cyc;
      first_xfer = -1;
      start = exp_pkts;
      n = 0;
      while (exp_pkts == start && n < 4000) begin
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        n++;
      end
      tx_ready = 1'b1;
      chk("pkt_done", 32'(exp_pkts - start), 32'd1);
      chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
      if (!rnd) begin
        chk("first_lat_ge2", 32'(first_xfer - stream_cyc >= 2), 32'd1);
        chk("rate", 32'(last_xfer - first_xfer), 32'(len - 1));
      end
      n = 0;
      while (busy && n < 200) begin
        tick();
        n++;
      end
      chk("gap_len", 32'(n), 32'(Ifg));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_fifo_re"}, 32'(fifo_re), 32'd0);
    chk({tag, "_tx_req"}, 32'(tx_req), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_last"}, 32'(tx_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_tx_len"}, 32'(tx_len), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int c0;
    // Reset state
    repeat (3) tick();
    srst = 1'b0;
    check_idle_outputs("reset");

    // Stray ack and stray fifo_valid while idle are ignored
    tx_ack = 1'b1;
    fifo_dout = 8'hA5;
    fifo_valid = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("stray_ack_req", 32'(tx_req), 32'd0);
    chk("stray_ack_busy", 32'(busy), 32'd0);
    chk("stray_valid", 32'(tx_valid), 32'd0);

    // One packet, ack after 3 cycles, ready always high
    preload(16, 8'h00);
    run_packet(3, PktLen, 1'b0);

    // Same packet with tx_ready randomly stalling
    preload(16, 8'h00);
    run_packet(1, PktLen, 1'b1);

    // 40 bytes: two back-to-back packets, 8 left behind
    preload(40, 8'(32 + $urandom_range(0, 100)));
    run_packet(int'($urandom_range(0, 3)), PktLen, 1'b0);
    run_packet(int'($urandom_range(0, 3)), PktLen, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_req) n++;
    end
    chk("no_req_partial", 32'(n), 32'd0);
    chk("fifo_left", 32'(fq.size()), 32'd8);
    chk("pkt_cnt_4", 32'(pkt_cnt), 32'd4);
    fq.delete();
    exp_bytes.delete();
    fifo_flags();
    tick();

    // Reset in the middle of a packet
    preload(16, 8'h40);
    n = 0;
    while (!tx_req && n < 100) begin
      tick();
      n++;
    end
    chk("mid_req_seen", 32'(tx_req), 32'd1);
    cur_len = PktLen;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    base = n_xfer;
    n = 0;
    while (n_xfer - base < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_five_bytes", 32'(n_xfer - base), 32'd5);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_idle_outputs("mid_reset");
    fq.delete();
    exp_bytes.delete();
    pos = 0;
    exp_pkts = 0;
    stall_q = 1'b0;
    fifo_flags();
    tick();
    check_idle_outputs("post_reset");

    // Partial packet of 5 bytes
    preload(5, 8'hC0);
    c0 = cyc;
`ifdef FLUSH_TIMEOUT_EN
    run_packet(2, 5, 1'b0);
    chk("flush_latency", 32'(req_cyc - c0), 32'(Flush + 1));
    chk("flush_pkt_cnt", 32'(pkt_cnt), 32'd1);
`else
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_req) n++;
    end
    chk("no_flush_req", 32'(n), 32'd0);
    chk("no_flush_busy", 32'(busy), 32'd0);
    chk("no_flush_left", 32'(fq.size()), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_fifo_ctrl.md
UDP_TX_FIFO_CTRL -- requirements
Module: udp_tx_fifo_ctrl

Interface
REQ-001 SHALL have parameter PKT_LEN, default 1024, giving the payload bytes per full packet (1..2048).
REQ-002 SHALL have parameter FLUSH_CYC, default 65535, giving the idle cycles before a partial flush (used only with FLUSH_TIMEOUT_EN).
REQ-003 SHALL have parameter IFG_CYC, default 12, giving the minimum idle cycles between packets.
REQ-004 SHALL have the following ports, in this order.
- clk  in  1  single clock; all logic on its rising edge.
- srst  in  1  synchronous reset, active-high.
- fifo_rdusedw  in  12  occupancy of the 8-bit byte FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_re  out  1  FIFO read enable (non-show-ahead).
- fifo_dout  in  8  FIFO read data.
- fifo_valid  in  1  fifo_dout is valid; asserted one cycle after an accepted fifo_re.
- tx_req  out  1  packet request to the UDP transmitter.
- tx_ack  in  1  transmitter accepts the request.
- tx_len  out  16  payload length of the requested packet.
- tx_data  out  8  payload byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data.
- tx_last  out  1  final byte of the packet.
- busy  out  1  high in every state except IDLE.
- pkt_cnt  out  16  count of completed packets; wraps modulo 2^16.

Function
REQ-005 SHALL implement the states IDLE, REQ, STREAM and GAP.
REQ-006 IDLE -> REQ when fifo_rdusedw >= PKT_LEN; tx_len SHALL be latched to PKT_LEN on that transition.
REQ-007 REQ SHALL hold tx_req=1 and tx_len stable until tx_ack=1; on tx_ack the block SHALL drop tx_req in the next cycle and enter STREAM.
REQ-008 STREAM SHALL issue exactly tx_len FIFO reads.
REQ-009 fifo_re SHALL be asserted only when all of the following hold: reads remaining > 0, fifo_empty=0, and (skid occupancy + reads in flight) < 2.
REQ-010 The block SHALL have a 2-entry skid buffer that captures fifo_dout whenever fifo_valid=1; no byte SHALL be dropped or duplicated under any tx_ready pattern.
REQ-011 tx_valid SHALL equal (skid non-empty); a byte is transferred when tx_valid && tx_ready; tx_data/tx_valid/tx_last SHALL hold stable while tx_ready=0.
REQ-012 tx_last SHALL be high only with the tx_len-th transferred byte; after that transfer the block SHALL increment pkt_cnt and enter GAP.
REQ-013 GAP SHALL last exactly IFG_CYC cycles, then go to IDLE.
REQ-014 Zero-occupancy operation: first tx_valid no earlier than 2 cycles after STREAM entry; sustained throughput 1 byte/cycle while tx_ready=1 and FIFO non-empty.
REQ-015 FIFO running empty mid-packet SHALL stall reads only; no state change, no timeout in STREAM.
REQ-016 tx_ack asserted outside REQ SHALL be ignored.
REQ-017 fifo_valid asserted with no read in flight SHALL be ignored.

Reset
REQ-018 srst=1 at a clock edge SHALL force IDLE from any state, including mid-packet.
REQ-019 srst=1 SHALL clear: fifo_re, tx_req, tx_valid, tx_last, busy, pkt_cnt, tx_len, skid contents, read counters and the timeout counter.
REQ-020 All outputs SHALL be 0 in the cycle after srst; srst SHALL take priority over every other input.

Configuration
REQ-021 Macro FLUSH_TIMEOUT_EN defined: in IDLE, a counter SHALL count cycles with 0 < fifo_rdusedw < PKT_LEN and clear otherwise.
REQ-022 With FLUSH_TIMEOUT_EN, when that counter reaches FLUSH_CYC the block SHALL enter REQ with tx_len = fifo_rdusedw sampled that cycle.
REQ-023 Macro FLUSH_TIMEOUT_EN undefined: no counter SHALL be present and only PKT_LEN packets SHALL be sent; FLUSH_CYC is then unused.

Verification
REQ-024 SHALL cover: PKT_LEN=16, preload 16 bytes 0x00..0x0F, tx_ack after 3 cycles, tx_ready=1 -> 16 bytes in order, tx_last on 0x0F, pkt_cnt=1, then IFG_CYC idle cycles.
REQ-025 SHALL cover: same stimulus with tx_ready randomly deasserted 50% of cycles -> identical byte sequence, no loss or duplication, outputs stable while stalled.
REQ-026 SHALL cover: preload 40 bytes, PKT_LEN=16 -> two back-to-back packets separated by exactly IFG_CYC cycles, 8 bytes left in the FIFO, pkt_cnt=2.
REQ-027 SHALL cover: srst pulsed after 5 bytes transferred -> next cycle all outputs 0, state IDLE, pkt_cnt=0.
REQ-028 SHALL cover, with FLUSH_TIMEOUT_EN and FLUSH_CYC=100: preload 5 bytes -> tx_req rises 101 cycles later with tx_len=5 and tx_last on the 5th byte.
REQ-029 SHALL cover, without FLUSH_TIMEOUT_EN: the same 5-byte preload -> tx_req never asserts.
